aud_recorder: RTL and testbench
===============================

# aud_recorder

Captures left-channel audio samples from the WM8731 ADC serial stream and writes them sequentially into SRAM for the lab3 recorder. Sits inside `Top` between the codec's ADC pins (`AUD_ADCDAT`, `AUD_ADCLRCK`, `AUD_BCLK`) and the SRAM write path. It is driven by the record/pause/stop key pulses decoded upstream. It reports the recorded length so the player knows where audio ends.

## Interface
- `DATA_W`, 16, sample width in bits (codec word length).
- `ADDR_W`, 20, SRAM word-address width.
- `MAX_ADDR`, 2**ADDR_W-1, last writable address; a write here ends recording.

Ports:
- `i_clk` in 1: audio bit clock (`AUD_BCLK`); all logic on the rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_lrc` in 1: ADC LR clock; low = left channel (I2S).
- `i_data` in 1: ADC serial data, MSB first.
- `i_start` in 1: one-cycle pulse; start a new recording, or resume when paused.
- `i_pause` in 1: one-cycle pulse; pause an active recording.
- `i_stop` in 1: one-cycle pulse; end the recording.
- `o_address` out ADDR_W: SRAM address of the current or next write.
- `o_data` out DATA_W: captured sample; valid while `o_wen`=1.
- `o_wen` out 1: one-cycle write strobe.
- `o_len` out ADDR_W+1: number of samples written in the current or last recording.
- `o_busy` out 1: recording is active or paused.
- `o_paused` out 1: in PAUSED.
- `o_full` out 1: the last recording ended because memory filled; sticky until the next start.

## Operation
- States: IDLE, WAIT_FALL, SHIFT, WRITE, PAUSED.
- **IDLE**
  - On `i_start`: clear `o_address`, `o_len` and `o_full`; go to WAIT_FALL.
  - All other inputs are ignored.
- **WAIT_FALL**
  - Wait for a falling edge of `i_lrc`, detected as registered previous value 1 and current value 0.
  - The detection cycle is the I2S skip bit. Go to SHIFT with the bit counter at 0.
- **SHIFT**
  - Each cycle shift `i_data` into the LSB of the sample register.
  - After the 16th bit (counter = DATA_W-1) go to WRITE.
- **WRITE**
  - `o_wen`=1 for exactly this cycle; `o_data` holds the full sample and `o_address` is unchanged.
  - Next cycle: `o_address`+1 and `o_len`+1.
  - If `o_address` was MAX_ADDR: set `o_full` and go to IDLE instead of incrementing the address. `o_len` still increments, to 2**ADDR_W.
  - Otherwise go to WAIT_FALL, or to PAUSED if a pause is pending.
- **Pause**
  - `i_pause` in WAIT_FALL goes to PAUSED immediately.
  - `i_pause` in SHIFT or WRITE sets a pending flag. The in-flight sample is still written, then the block enters PAUSED.
- **PAUSED**
  - `i_start` goes to WAIT_FALL with address and length preserved.
  - `i_pause` is ignored.
- **Stop**
  - `i_stop` in any non-IDLE state goes to IDLE next cycle.
  - Any sample in flight is discarded; `o_wen` is not asserted.
  - `o_len` and `o_address` hold their values.
- **Priority** for simultaneous pulses: stop > pause > start.
- Arithmetic: unsigned, no wrap. The address never exceeds MAX_ADDR.

## Timing
- Reset values: all outputs 0, state IDLE, pause flag 0, LRC history 1.
- Reset asserted mid-operation aborts immediately; no write strobe is issued.
- Falling-edge detect cycle is t. Bits 15..0 are sampled at cycles t+1..t+16. `o_wen` is high in cycle t+17. Address and length update at t+18.
- Exactly one write per LRC period; each sample ends 1 cycle after its LSB.
- An LRC falling edge that occurs during SHIFT or WRITE is ignored; the next period is used.
- `o_busy` = state ≠ IDLE, registered together with the state.

## Structure
- Package `aud_pkg`:
  - `rec_state_t` enum.
  - `AUD_DATA_W`=16 and `SRAM_ADDR_W`=20, shared with the player and DSP stages.
- One natural sub-module: `i2s_shift_in`, a 16-bit serial-to-parallel shifter with a bit counter and a done pulse.
  - Inputs: load-enable, serial bit.
  - Outputs: sample, done.
- The FSM, address/length counters and pause flag live in `aud_recorder`.

## Test plan
- **Basic capture:** start, then LRC falls and `i_data` carries 16'hA5C3 MSB first. Expect `o_wen` at t+17 with `o_data`=16'hA5C3 and `o_address`=0; then `o_address`=1 and `o_len`=1.
- **Back-to-back:** 4 LRC periods carrying 0x0001, 0x8000, 0xFFFF, 0x1234. Expect 4 strobes at addresses 0..3 with matching data, and `o_len`=4.
- **Pause mid-sample:** pause at bit 8 of sample 2. Expect sample 2 written, then `o_paused`=1 and no strobes over 3 LRC periods. Start resumes at address 2.
- **Stop mid-sample:** stop at bit 5 of sample 3. Expect no strobe, IDLE, `o_len`=3, `o_busy`=0.
- **Full:** with `ADDR_W`=3, record 9 periods. Expect 8 writes at addresses 0..7, then `o_full`=1, `o_len`=8, IDLE, and no 9th write.
- **Reset and simultaneous events:**
  - Pulse `i_rst_n` low during SHIFT: all outputs 0 asynchronously and no strobe.
  - Stop and start in the same cycle while recording: expect IDLE.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared audio-path definitions: sample/SRAM widths and the recorder state encoding.
package aud_pkg;

  localparam int AUD_DATA_W  = 16;
  localparam int SRAM_ADDR_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FALL = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_WRITE     = 3'd3,
    ST_PAUSED    = 3'd4
  } rec_state_t;

endpackage

// File: rtl/aud_recorder_if.sv
// Recorder bundle: ADC serial pins, key pulses, SRAM write path and recording status.
interface aud_recorder_if
  import aud_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W,
  parameter int ADDR_W = SRAM_ADDR_W
) ();

  logic              i_lrc;
  logic              i_data;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_wen;
  logic [ADDR_W:0]   o_len;
  logic              o_busy;
  logic              o_paused;
  logic              o_full;

  modport master (
    output i_lrc, i_data, i_start, i_pause, i_stop,
    input  o_address, o_data, o_wen, o_len, o_busy, o_paused, o_full
  );

  modport slave (
    input  i_lrc, i_data, i_start, i_pause, i_stop,
    output o_address, o_data, o_wen, o_len, o_busy, o_paused, o_full
  );

endinterface

// File: rtl/i2s_shift_in.sv
// Serial-to-parallel shifter, MSB first; done is high during the cycle the last bit is taken.
module i2s_shift_in
  import aud_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              ser_bit,
  output logic [DATA_W-1:0] sample,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] sample_r;

  // Shift register and bit counter; the counter rests at zero whenever shifting stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      sample_r <= '0;
    end else if (load_en) begin
      sample_r <= {sample_r[DATA_W-2:0], ser_bit};
      cnt_r    <= (cnt_r == CNT_LAST) ? '0 : (cnt_r + CNT_ONE);
    end else begin
      cnt_r    <= '0;
    end
  end

  assign sample = sample_r;
  assign done   = load_en && (cnt_r == CNT_LAST);

endmodule

// File: rtl/aud_recorder.sv
// Left-channel I2S capture from the WM8731 ADC into sequential SRAM writes,
// with start/pause/stop control and a recorded-length report for the player.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int                DATA_W   = AUD_DATA_W,
  parameter int                ADDR_W   = SRAM_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input logic           i_clk,
  input logic           i_rst_n,
  aud_recorder_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  rec_state_t        state_r;
  rec_state_t        state_s;
  logic              pend_r;
  logic              pend_s;
  logic              lrc_prev_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   len_r;
  logic              full_r;
  logic              wen_r;
  logic              busy_r;
  logic              paused_r;
  logic              fall_s;
  logic              at_max_s;
  logic              clear_s;
  logic              shift_en_s;
  logic              done_s;
  logic [DATA_W-1:0] sample_s;

  assign fall_s     = lrc_prev_r && !bus.i_lrc;
  assign at_max_s   = (addr_r == MAX_ADDR);
  assign clear_s    = (state_r == ST_IDLE) && bus.i_start;
  assign shift_en_s = (state_r == ST_SHIFT);

  i2s_shift_in #(.DATA_W(DATA_W)) u_shift (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load_en (shift_en_s),
    .ser_bit (bus.i_data),
    .sample  (sample_s),
    .done    (done_s)
  );

  // Next-state logic; stop outranks pause, which outranks start.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_s = ST_WAIT_FALL;
          pend_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_FALL: begin
        if (bus.i_stop) begin
          state_s = ST_IDLE;
          pend_s  = 1'b0;
        end else if (bus.i_pause) begin
          state_s = ST_PAUSED;
        end else if (fall_s) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_WAIT_FALL;
        end
      end
      ST_SHIFT: begin
        if (bus.i_stop) begin
          state_s = ST_IDLE;
          pend_s  = 1'b0;
        end else begin
          if (bus.i_pause) begin
            pend_s = 1'b1;
          end else begin
            pend_s = pend_r;
          end
          if (done_s) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_SHIFT;
          end
        end
      end
      ST_WRITE: begin
        pend_s = 1'b0;
        if (bus.i_stop || at_max_s) begin
          state_s = ST_IDLE;
        end else if (pend_r || bus.i_pause) begin
          state_s = ST_PAUSED;
        end else begin
          state_s = ST_WAIT_FALL;
        end
      end
      ST_PAUSED: begin
        if (bus.i_stop) begin
          state_s = ST_IDLE;
        end else if (bus.i_pause) begin
          state_s = ST_PAUSED;
        end else if (bus.i_start) begin
          state_s = ST_WAIT_FALL;
        end else begin
          state_s = ST_PAUSED;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pend_s  = 1'b0;
      end
    endcase
  end

  // State register; status flags and the write strobe are registered alongside it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      pend_r     <= 1'b0;
      lrc_prev_r <= 1'b1;
      wen_r      <= 1'b0;
      busy_r     <= 1'b0;
      paused_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      pend_r     <= pend_s;
      lrc_prev_r <= bus.i_lrc;
      wen_r      <= (state_s == ST_WRITE);
      busy_r     <= (state_s != ST_IDLE);
      paused_r   <= (state_s == ST_PAUSED);
    end
  end

  // Address/length advance the cycle after each strobe; the address saturates at MAX_ADDR.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_r <= '0;
      len_r  <= '0;
      full_r <= 1'b0;
    end else if (clear_s) begin
      addr_r <= '0;
      len_r  <= '0;
      full_r <= 1'b0;
    end else if (state_r == ST_WRITE) begin
      len_r <= len_r + LEN_ONE;
      if (at_max_s) begin
        full_r <= 1'b1;
      end else begin
        addr_r <= addr_r + ADDR_ONE;
      end
    end
  end

  assign bus.o_address = addr_r;
  assign bus.o_data    = sample_s;
  assign bus.o_wen     = wen_r;
  assign bus.o_len     = len_r;
  assign bus.o_busy    = busy_r;
  assign bus.o_paused  = paused_r;
  assign bus.o_full    = full_r;

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder: a 20-bit-address instance for capture/pause/stop/reset
// and a 3-bit-address instance for the memory-full case, with write scoreboards per instance.
module tb_aud_recorder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int wen_cnt  = 0;
  int swen_cnt = 0;
  int wen_cycle;
  int b_addr;
  int s_addr;
  int snap;

  logic [35:0] exp_q[$];
  logic [35:0] sexp_q[$];
  logic [35:0] mon_e;
  logic [35:0] smon_e;

  aud_recorder_if #(.DATA_W(16), .ADDR_W(20)) bus ();
  aud_recorder_if #(.DATA_W(16), .ADDR_W(3))  sbus ();

  aud_recorder #(.DATA_W(16), .ADDR_W(20)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  aud_recorder #(.DATA_W(16), .ADDR_W(3)) u_small (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (sbus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    assert (act === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic st, input logic pa, input logic sp);
    bus.i_start = st;
    bus.i_pause = pa;
    bus.i_stop  = sp;
    tick();
    bus.i_start = 1'b0;
    bus.i_pause = 1'b0;
    bus.i_stop  = 1'b0;
  endtask

  // ev: 0 none, 1 pause, 2 stop, 3 async reset, applied in period cycle ev_k
  task automatic send_sample(input logic [15:0] v, input int tgt, input bit push,
                             input int ev, input int ev_k);
    logic w;
    wen_cycle = -1;
    if (push && tgt == 0) begin
      exp_q.push_back({20'(b_addr), v});
      b_addr++;
    end
    if (push && tgt == 1) begin
      sexp_q.push_back({20'(s_addr), v});
      s_addr++;
    end
    for (int k = 0; k < 40; k++) begin
      bus.i_lrc   = (k < 20) ? 1'b0 : 1'b1;
      sbus.i_lrc  = bus.i_lrc;
      bus.i_data  = (k >= 1 && k <= 16) ? v[16-k] : 1'b0;
      sbus.i_data = bus.i_data;
      if (k == ev_k && ev == 1) bus.i_pause = 1'b1;
      if (k == ev_k && ev == 2) bus.i_stop = 1'b1;
      if (k == ev_k && ev == 3) begin
        rst_n = 1'b0;
        #1;
        check("rst_address", 32'(bus.o_address), 32'd0);
        check("rst_len",     32'(bus.o_len),     32'd0);
        check("rst_busy",    32'(bus.o_busy),    32'd0);
        check("rst_wen",     32'(bus.o_wen),     32'd0);
        check("rst_data",    32'(bus.o_data),    32'd0);
      end
      tick();
      bus.i_pause = 1'b0;
      bus.i_stop  = 1'b0;
      w = (tgt == 0) ? bus.o_wen : sbus.o_wen;
      if (w === 1'b1 && wen_cycle < 0) wen_cycle = k + 1;
    end
    if (ev == 3) rst_n = 1'b1;
  endtask

  // Write monitor for the wide instance
  always begin
    @(posedge clk);
    #1;
    if (bus.o_wen === 1'b1) begin
      wen_cnt++;
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.o_address), 32'(mon_e[35:16]));
        check("wr_data", 32'(bus.o_data),    32'(mon_e[15:0]));
      end
    end
  end

  // Write monitor for the 3-bit-address instance
  always begin
    @(posedge clk);
    #1;
    if (sbus.o_wen === 1'b1) begin
      swen_cnt++;
      check("swr_expected", 32'(sexp_q.size() != 0), 32'd1);
      if (sexp_q.size() != 0) begin
        smon_e = sexp_q.pop_front();
        check("swr_addr", 32'(sbus.o_address), 32'(smon_e[35:16]));
        check("swr_data", 32'(sbus.o_data),    32'(smon_e[15:0]));
      end
    end
  end

  initial begin
    bus.i_lrc = 1'b1;  bus.i_data = 1'b0;
    bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0;
    sbus.i_lrc = 1'b1; sbus.i_data = 1'b0;
    sbus.i_start = 1'b0; sbus.i_pause = 1'b0; sbus.i_stop = 1'b0;
    b_addr = 0;
    s_addr = 0;

    repeat (3) tick();
    check("reset_address", 32'(bus.o_address), 32'd0);
    check("reset_len",     32'(bus.o_len),     32'd0);
    check("reset_busy",    32'(bus.o_busy),    32'd0);
    check("reset_wen",     32'(bus.o_wen),     32'd0);
    check("reset_paused",  32'(bus.o_paused),  32'd0);
    check("reset_full",    32'(bus.o_full),    32'd0);
    check("reset_data",    32'(bus.o_data),    32'd0);
    rst_n = 1'b1;
    tick();

    // basic capture
    pulse(1'b1, 1'b0, 1'b0);
    check("start_busy", 32'(bus.o_busy), 32'd1);
    send_sample(16'hA5C3, 0, 1'b1, 0, -1);
    check("basic_wen_cycle", 32'(wen_cycle), 32'd17);
    check("basic_address",   32'(bus.o_address), 32'd1);
    check("basic_len",       32'(bus.o_len), 32'd1);

    // back-to-back in a fresh recording
    pulse(1'b0, 1'b0, 1'b1);
    check("stop_idle", 32'(bus.o_busy), 32'd0);
    check("stop_len_hold", 32'(bus.o_len), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    check("restart_len_clear", 32'(bus.o_len), 32'd0);
    b_addr = 0;
    send_sample(16'h0001, 0, 1'b1, 0, -1);
    send_sample(16'h8000, 0, 1'b1, 0, -1);
    send_sample(16'hFFFF, 0, 1'b1, 0, -1);
    send_sample(16'h1234, 0, 1'b1, 0, -1);
    check("b2b_len",     32'(bus.o_len), 32'd4);
    check("b2b_address", 32'(bus.o_address), 32'd4);
    check("b2b_strobes", 32'(wen_cnt), 32'd5);

    // pause in the middle of sample 2
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    b_addr = 0;
    send_sample(16'h1111, 0, 1'b1, 0, -1);
    send_sample(16'h2222, 0, 1'b1, 1, 9);
    check("pause_paused", 32'(bus.o_paused), 32'd1);
    check("pause_busy",   32'(bus.o_busy), 32'd1);
    snap = wen_cnt;
    send_sample(16'hDEAD, 0, 1'b0, 0, -1);
    send_sample(16'hBEEF, 0, 1'b0, 0, -1);
    send_sample(16'hCAFE, 0, 1'b0, 0, -1);
    check("pause_no_strobe", 32'(wen_cnt), 32'(snap));
    check("pause_address",   32'(bus.o_address), 32'd2);
    pulse(1'b1, 1'b0, 1'b0);
    check("resume_unpaused", 32'(bus.o_paused), 32'd0);
    send_sample(16'h3333, 0, 1'b1, 0, -1);
    check("resume_len",     32'(bus.o_len), 32'd3);
    check("resume_address", 32'(bus.o_address), 32'd3);

    // stop in the middle of the fourth sample
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    b_addr = 0;
    send_sample(16'h0F0F, 0, 1'b1, 0, -1);
    send_sample(16'hF0F0, 0, 1'b1, 0, -1);
    send_sample(16'h5A5A, 0, 1'b1, 0, -1);
    snap = wen_cnt;
    send_sample(16'h4444, 0, 1'b0, 2, 6);
    check("stop_no_strobe", 32'(wen_cnt), 32'(snap));
    check("stop_busy",      32'(bus.o_busy), 32'd0);
    check("stop_len",       32'(bus.o_len), 32'd3);
    check("stop_address",   32'(bus.o_address), 32'd3);

    // simultaneous pulses while waiting for LRC
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    check("stop_start_idle", 32'(bus.o_busy), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    check("pause_over_start", 32'(bus.o_paused), 32'd1);
    pulse(1'b0, 1'b1, 1'b1);
    check("stop_over_pause", 32'(bus.o_busy), 32'd0);

    // asynchronous reset during SHIFT
    pulse(1'b1, 1'b0, 1'b0);
    b_addr = 0;
    send_sample(16'h5555, 0, 1'b1, 0, -1);
    check("prerst_address", 32'(bus.o_address), 32'd1);
    snap = wen_cnt;
    send_sample(16'h6666, 0, 1'b0, 3, 8);
    tick();
    check("rst_no_strobe", 32'(wen_cnt), 32'(snap));
    check("postrst_busy",  32'(bus.o_busy), 32'd0);
    check("postrst_len",   32'(bus.o_len), 32'd0);

    // memory full on the 3-bit instance
    sbus.i_start = 1'b1;
    tick();
    sbus.i_start = 1'b0;
    s_addr = 0;
    for (int i = 0; i < 9; i++) begin
      send_sample(16'(i * 4099 + 7), 1, (i < 8), 0, -1);
    end
    check("full_flag",    32'(sbus.o_full), 32'd1);
    check("full_len",     32'(sbus.o_len), 32'd8);
    check("full_busy",    32'(sbus.o_busy), 32'd0);
    check("full_strobes", 32'(swen_cnt), 32'd8);
    check("full_address", 32'(sbus.o_address), 32'd7);

    check("queue_empty",  32'(exp_q.size()), 32'd0);
    check("squeue_empty", 32'(sexp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
